argmin_stream_sequencer: RTL and testbench
==========================================

Name: argmin_stream_sequencer

Overview:
- Sequences a streaming argmin-over-a-dimension operation for the argmin operator family.
- Accepts a job config of dim length and row count, then consumes one element per cycle over a valid/ready input stream.
- Emits one minimum index per row over a valid/ready output stream, and signals job completion.
- Sits between the tensor fetch stream and the result writer in the operator pipeline.

Parameters:
- DATA_W, 32, element width; elements are compared as two's-complement signed values.
- LEN_W, 16, width of the dim-length config and of the output index.
- ROW_W, 16, width of the row-count config and of the row tag.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  job config offered.
- cfg_ready  out  1  sequencer can accept a config (IDLE only).
- cfg_dim_len  in  LEN_W  elements per row (reduced dimension size).
- cfg_num_rows  in  ROW_W  rows in the job.
- in_valid  in  1  input element offered.
- in_ready  out  1  sequencer accepts element (SCAN only).
- in_data  in  DATA_W  input element, signed.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_index  out  LEN_W  argmin index within the row, 0-based.
- out_row  out  ROW_W  row number of the result, 0-based.
- busy  out  1  high in SCAN or EMIT.
- done  out  1  one-cycle pulse when the last row's result is accepted.
- cfg_err  out  1  one-cycle pulse when a config is rejected.

Behaviour:
- Reset (async assert, any state):
  - State goes to IDLE; partial row and job are discarded.
  - Outputs: cfg_ready=1, in_ready=0, out_valid=0, busy=0, done=0, cfg_err=0, out_index=0, out_row=0.
  - Internal min, element index and row counter are cleared.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: if dim_len==0 or num_rows==0, pulse cfg_err next cycle and stay in IDLE.
  - Otherwise latch both config values, clear idx and row, and go to SCAN.
- SCAN:
  - in_ready=1, cfg_ready=0.
  - Per accepted element (in_valid&in_ready): if idx==0 or in_data < min (strict signed compare), load min=in_data and min_idx=idx.
  - Ties keep the earliest index (first occurrence).
  - When the element with idx==dim_len-1 is accepted: register the final min_idx, including that element, into out_index, then go to EMIT. Otherwise idx++.
  - in_valid low: hold all state; no timeout.
- EMIT:
  - out_valid=1, in_ready=0.
  - out_index and out_row are stable while out_valid=1 and out_ready=0.
  - On out_ready: if row==num_rows-1, pulse done in the same cycle as the handshake and go to IDLE.
  - Otherwise row++, idx=0, go to SCAN.
- Latency and throughput:
  - out_valid rises the cycle after the last element of a row is accepted.
  - Steady-state rate is dim_len+1 cycles per row with no backpressure.
  - dim_len==1 gives out_index=0 after one element.
- out_index and out_row keep their last value when out_valid=0.
- Counters are LEN_W/ROW_W wide; maximum values are dim_len=2^LEN_W-1 and num_rows=2^ROW_W-1. No wrap occurs within a legal job.
- Config changes on cfg_* while not in IDLE are ignored.
- busy = state!=IDLE.

Test Plan:
- Config dim_len=4, rows=1; stream 5,-3,7,2 -> out_index=1, out_row=0, done pulses on out_ready; FSM returns to IDLE.
- dim_len=5, rows=1; stream 9,2,8,2,2 (ties) -> out_index=1 (first occurrence kept).
- dim_len=3, rows=3 with rows {1,0,2},{-1,-5,-5},{7,7,7} -> results (1,row0), (1,row1), (0,row2) in order; done pulses only after row 2.
- Hold out_ready=0 for 10 cycles in EMIT -> out_valid stays 1, out_index/out_row stable, in_ready=0; in_valid gaps during SCAN stall without corrupting min.
- Config dim_len=0 (and separately rows=0) -> cfg_err one-cycle pulse, busy stays 0, next valid config accepted normally.
- Assert rst mid-row (after 2 of 4 elements) -> outputs return to reset values immediately; a new job of 0x7FFFFFFF, 0x80000000 gives out_index=1 (signed compare).

Source files
------------

// File: rtl/argmin_stream_sequencer.sv
// ============================================================================
// Module   : argmin_stream_sequencer
// Purpose  : Streaming argmin over the reduced dimension. Takes a job config
//            (dim length, row count), consumes one signed element per cycle
//            and emits one minimum index per row, then signals completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmin_stream_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int ROW_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // job configuration
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LEN_W-1:0]  cfg_dim_len,
    input  logic [ROW_W-1:0]  cfg_num_rows,
    // element stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    // result stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN_W-1:0]  out_index,
    output logic [ROW_W-1:0]  out_row,
    // status
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0] c_row_one = {{(ROW_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_dim_len;
    logic [ROW_W-1:0]   r_num_rows;
    logic [LEN_W-1:0]   r_idx;
    logic [ROW_W-1:0]   r_row;
    logic [DATA_W-1:0]  r_min;
    logic [LEN_W-1:0]   r_min_idx;
    logic [LEN_W-1:0]   r_out_index;
    logic [ROW_W-1:0]   r_out_row;
    logic               r_cfg_err;

    logic               w_cfg_bad;
    logic               w_new_min;
    logic               w_last_elem;
    logic               w_last_row;

    // A zero-length dimension or zero rows would make an empty job; reject it.
    assign w_cfg_bad   = (cfg_dim_len == '0) || (cfg_num_rows == '0);
    // First element of a row always seeds the minimum; later ones must be
    // strictly smaller so ties keep the earliest index.
    assign w_new_min   = (r_idx == '0) || ($signed(in_data) < $signed(r_min));
    assign w_last_elem = (r_idx == (r_dim_len - c_len_one));
    assign w_last_row  = (r_row == (r_num_rows - c_row_one));

    assign cfg_ready = (r_state == S_IDLE);
    assign in_ready  = (r_state == S_SCAN);
    assign out_valid = (r_state == S_EMIT);
    assign busy      = (r_state != S_IDLE);
    // done must coincide with the final result handshake, so it is decoded
    // from the registered state and the live out_ready.
    assign done      = (r_state == S_EMIT) && out_ready && w_last_row;
    assign cfg_err   = r_cfg_err;
    assign out_index = r_out_index;
    assign out_row   = r_out_row;

    // Sequencer FSM: config capture, per-row min tracking and result hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dim_len   <= '0;
            r_num_rows  <= '0;
            r_idx       <= '0;
            r_row       <= '0;
            r_min       <= '0;
            r_min_idx   <= '0;
            r_out_index <= '0;
            r_out_row   <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_dim_len  <= cfg_dim_len;
                            r_num_rows <= cfg_num_rows;
                            r_idx      <= '0;
                            r_row      <= '0;
                            r_state    <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (in_valid) begin
                        if (w_new_min) begin
                            r_min     <= in_data;
                            r_min_idx <= r_idx;
                        end
                        if (w_last_elem) begin
                            // The last element participates in the result.
                            r_out_index <= w_new_min ? r_idx : r_min_idx;
                            r_out_row   <= r_row;
                            r_state     <= S_EMIT;
                        end else begin
                            r_idx <= r_idx + c_len_one;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (w_last_row) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_row   <= r_row + c_row_one;
                            r_idx   <= '0;
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_argmin_stream_sequencer.sv
// ============================================================================
// Module   : tb_argmin_stream_sequencer
// Purpose  : Directed self-checking bench for argmin_stream_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argmin_stream_sequencer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int ROW_W  = 16;
    localparam int c_wait_max = 100;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [LEN_W-1:0]  cfg_dim_len;
    logic [ROW_W-1:0]  cfg_num_rows;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LEN_W-1:0]  out_index;
    logic [ROW_W-1:0]  out_row;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int n_vec;
    int n_err;

    argmin_stream_sequencer #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .ROW_W (ROW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_dim_len (cfg_dim_len),
        .cfg_num_rows(cfg_num_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_row     (out_row),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [LEN_W-1:0] dl, input logic [ROW_W-1:0] nr);
        cfg_valid    = 1'b1;
        cfg_dim_len  = dl;
        cfg_num_rows = nr;
        tick();
        cfg_valid    = 1'b0;
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < c_wait_max) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [LEN_W-1:0] e_idx,
                               input logic [ROW_W-1:0] e_row, input logic e_done);
        int n;
        n = 0;
        while (!out_valid && n < c_wait_max) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_idx"},   64'(out_index), 64'(e_idx));
        chk({tag, "_row"},   64'(out_row),   64'(e_row));
        out_ready = 1'b1;
        #1;
        chk({tag, "_done"},  64'(done),      64'(e_done));
        tick();
        out_ready = 1'b0;
        #1;
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [LEN_W-1:0] hold_idx;
        logic [ROW_W-1:0] hold_row;

        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_dim_len  = '0;
        cfg_num_rows = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_cfg_err",   64'(cfg_err),   64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_row",   64'(out_row),   64'd0);

        // single row 5,-3,7,2 -> index 1
        send_cfg(16'd4, 16'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cfg_ready", 64'(cfg_ready), 64'd0);
        send_elem(32'd5);
        send_elem(-32'sd3);
        send_elem(32'd7);
        send_elem(32'd2);
        chk("t1_latency", 64'(out_valid), 64'd1);
        take_result("t1", 16'd1, 16'd0, 1'b1);
        chk("t1_idle", 64'(cfg_ready), 64'd1);
        chk("t1_busy_lo", 64'(busy), 64'd0);

        // ties keep first occurrence: 9,2,8,2,2 -> 1
        send_cfg(16'd5, 16'd1);
        send_elem(32'd9);
        send_elem(32'd2);
        send_elem(32'd8);
        send_elem(32'd2);
        send_elem(32'd2);
        take_result("t2", 16'd1, 16'd0, 1'b1);

        // three rows
        send_cfg(16'd3, 16'd3);
        send_elem(32'd1);   send_elem(32'd0);    send_elem(32'd2);
        take_result("t3r0", 16'd1, 16'd0, 1'b0);
        send_elem(-32'sd1); send_elem(-32'sd5);  send_elem(-32'sd5);
        take_result("t3r1", 16'd1, 16'd1, 1'b0);
        send_elem(32'd7);   send_elem(32'd7);    send_elem(32'd7);
        take_result("t3r2", 16'd0, 16'd2, 1'b1);

        // input gaps and output backpressure: 3,-8,0,-8 -> 1
        send_cfg(16'd4, 16'd1);
        send_elem(32'd3);
        tick(); tick(); tick();
        chk("t4_gap_in_ready", 64'(in_ready), 64'd1);
        send_elem(-32'sd8);
        tick(); tick();
        send_elem(32'd0);
        tick();
        send_elem(-32'sd8);
        hold_idx = out_index;
        hold_row = out_row;
        chk("t4_hold_idx0", 64'(hold_idx), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
            chk("t4_hold_idx", 64'(out_index), 64'(hold_idx));
            chk("t4_hold_row", 64'(out_row), 64'(hold_row));
            tick();
        end
        take_result("t4", 16'd1, 16'd0, 1'b1);

        // illegal configs
        send_cfg(16'd0, 16'd3);
        chk("t5a_cfg_err", 64'(cfg_err), 64'd1);
        chk("t5a_busy", 64'(busy), 64'd0);
        tick();
        chk("t5a_cfg_err_lo", 64'(cfg_err), 64'd0);
        send_cfg(16'd4, 16'd0);
        chk("t5b_cfg_err", 64'(cfg_err), 64'd1);
        chk("t5b_busy", 64'(busy), 64'd0);
        tick();
        chk("t5b_cfg_err_lo", 64'(cfg_err), 64'd0);
        send_cfg(16'd1, 16'd1);
        chk("t5c_busy", 64'(busy), 64'd1);
        chk("t5c_cfg_err", 64'(cfg_err), 64'd0);
        send_elem(32'd42);
        take_result("t5c", 16'd0, 16'd0, 1'b1);

        // reset mid-row, then signed extremes
        send_cfg(16'd4, 16'd1);
        send_elem(32'd10);
        send_elem(32'd11);
        rst = 1'b1;
        #1;
        chk("t6_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("t6_rst_in_ready",  64'(in_ready),  64'd0);
        chk("t6_rst_busy",      64'(busy),      64'd0);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_out_index", 64'(out_index), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        send_cfg(16'd2, 16'd1);
        send_elem(32'h7FFF_FFFF);
        send_elem(32'h8000_0000);
        take_result("t6", 16'd1, 16'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
